// File: rtl/apb_pkg.sv
// Shared definitions for the APB register slave: bus widths, FSM states
// and the address decode rule used by apb_slave_regs.
// Optional feature macro: APB_SLAVE_WAIT_EN (wait-state insertion in the top).
package apb_pkg;

    localparam int APB_AW = 32;
    localparam int APB_DW = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } apb_state_e;

    // Word-aligned, inside the bank, and never a write to the read-only ID register.
    function automatic logic addr_ok(input logic [9:0] addr,
                                     input logic       write,
                                     input int         nregs);
        logic [7:0] idx;
        idx = addr[9:2];
        return (addr[1:0] == 2'b00) && (int'(idx) < nregs) && !(write && (idx == 8'd0));
    endfunction

endpackage

// File: rtl/apb_regbank.sv
// Register storage for the APB slave. Index 0 is a read-only ID constant;
// indices 1..NREGS-1 are writable and cleared by reset. Read is a plain
// combinational mux so the top can register it together with PREADY.
module apb_regbank
    import apb_pkg::*;
#(
    parameter int                NREGS    = 8,
    parameter logic [APB_DW-1:0] ID_VALUE = 32'hA5B0_0001
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              we_i,
    input  logic [7:0]        idx_i,
    input  logic [APB_DW-1:0] wdata_i,
    output logic [APB_DW-1:0] rdata_o
);

    logic [NREGS-1:0][APB_DW-1:0] reg_flat;

    assign reg_flat[0] = ID_VALUE;

    for (genvar gi = 1; gi < NREGS; gi++) begin : g_reg
        logic [APB_DW-1:0] q;

        // One writable word; only updated when the commit targets this index.
        always_ff @(posedge clk_i or negedge rst_ni) begin
            if (!rst_ni) begin
                q <= '0;
            end else if (we_i && (idx_i == 8'(gi))) begin
                q <= wdata_i;
            end
        end

        assign reg_flat[gi] = q;
    end

    // Read mux; out-of-range indices read as zero (the top flags them anyway).
    always_comb begin
        rdata_o = '0;
        for (int i = 0; i < NREGS; i++) begin
            if (idx_i == 8'(i)) begin
                rdata_o = reg_flat[i];
            end
        end
    end

endmodule

// File: rtl/apb_slave_regs.sv
// APB3 completer in front of a small register bank. A transfer walks
// IDLE -> WAIT -> RESP -> IDLE; PRDATA/PREADY/PSLVERR are all registered and
// PREADY is high for exactly the RESP cycle.
// Optional feature macro: APB_SLAVE_WAIT_EN. When defined, WAIT_CYCLES access
// edges are swallowed before the response; otherwise the first access edge
// completes the transfer and WAIT_CYCLES is ignored.
module apb_slave_regs
    import apb_pkg::*;
#(
    parameter int                NREGS       = 8,
    parameter int                WAIT_CYCLES = 2,
    parameter logic [APB_DW-1:0] ID_VALUE    = 32'hA5B0_0001
) (
    input  logic              PCLK,
    input  logic              PRESETn,
    input  logic              PSEL,
    input  logic              PENABLE,
    input  logic              PWRITE,
    input  logic [APB_AW-1:0] PADDR,
    input  logic [APB_DW-1:0] PWDATA,
    output logic [APB_DW-1:0] PRDATA,
    output logic              PREADY,
    output logic              PSLVERR
);

    apb_state_e        state_q, state_d;
    logic [9:0]        addr_q, addr_d;
    logic              write_q, write_d;
    logic [APB_DW-1:0] wdata_q, wdata_d;
    logic [APB_DW-1:0] prdata_q, prdata_d;
    logic              pready_q, pready_d;
    logic              pslverr_q, pslverr_d;

    logic              reg_we;
    logic [APB_DW-1:0] reg_rdata;
    logic              access_ok;

    // Address bits above the 256-word window do not take part in decode.
    logic [APB_AW-11:0] unused_paddr;
    assign unused_paddr = PADDR[APB_AW-1:10];

`ifdef APB_SLAVE_WAIT_EN
    localparam int CNT_W = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES + 1) : 1;
    logic [CNT_W-1:0] cnt_q, cnt_d;
`else
    logic [31:0] unused_wait_cycles;
    assign unused_wait_cycles = 32'(WAIT_CYCLES);
`endif

    assign access_ok = addr_ok(addr_q, write_q, NREGS);

    apb_regbank #(
        .NREGS    (NREGS),
        .ID_VALUE (ID_VALUE)
    ) u_regbank (
        .clk_i   (PCLK),
        .rst_ni  (PRESETn),
        .we_i    (reg_we),
        .idx_i   (addr_q[9:2]),
        .wdata_i (wdata_q),
        .rdata_o (reg_rdata)
    );

    // Transfer sequencing and response generation.
    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        write_d   = write_q;
        wdata_d   = wdata_q;
        prdata_d  = prdata_q;
        pready_d  = pready_q;
        pslverr_d = pslverr_q;
        reg_we    = 1'b0;
`ifdef APB_SLAVE_WAIT_EN
        cnt_d     = cnt_q;
`endif
        unique case (state_q)
            IDLE: begin
                pready_d  = 1'b0;
                pslverr_d = 1'b0;
                prdata_d  = '0;
                if (PSEL && !PENABLE) begin
                    state_d = WAIT;
                    addr_d  = PADDR[9:0];
                    write_d = PWRITE;
                    wdata_d = PWDATA;
`ifdef APB_SLAVE_WAIT_EN
                    cnt_d   = CNT_W'(WAIT_CYCLES);
`endif
                end
            end
            WAIT: begin
                if (!PSEL) begin
                    // Master walked away: drop the transfer without touching the bank.
                    state_d = IDLE;
                end else if (PENABLE) begin
`ifdef APB_SLAVE_WAIT_EN
                    if (cnt_q != '0) begin
                        cnt_d = cnt_q - 1'b1;
                    end else
`endif
                    begin
                        state_d   = RESP;
                        pready_d  = 1'b1;
                        pslverr_d = !access_ok;
                        reg_we    = write_q && access_ok;
                        prdata_d  = (!write_q && access_ok) ? reg_rdata : '0;
                    end
                end
            end
            RESP: begin
                // Any setup presented here is ignored; master retries from IDLE.
                state_d   = IDLE;
                pready_d  = 1'b0;
                pslverr_d = 1'b0;
                prdata_d  = '0;
            end
            default: begin
                state_d   = IDLE;
                pready_d  = 1'b0;
                pslverr_d = 1'b0;
                prdata_d  = '0;
            end
        endcase
    end

    // State and registered bus outputs.
    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            state_q   <= IDLE;
            addr_q    <= '0;
            write_q   <= 1'b0;
            wdata_q   <= '0;
            prdata_q  <= '0;
            pready_q  <= 1'b0;
            pslverr_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            write_q   <= write_d;
            wdata_q   <= wdata_d;
            prdata_q  <= prdata_d;
            pready_q  <= pready_d;
            pslverr_q <= pslverr_d;
        end
    end

`ifdef APB_SLAVE_WAIT_EN
    // Wait-state down-counter.
    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end
`endif

    assign PRDATA  = prdata_q;
    assign PREADY  = pready_q;
    assign PSLVERR = pslverr_q;

endmodule

// File: tb/tb_apb_slave_regs.sv
// Self-checking bench for apb_slave_regs: directed corner cases followed by
// random read/write traffic, all compared against a word-array model of the
// register bank. Honours APB_SLAVE_WAIT_EN for the expected PREADY latency.
module tb_apb_slave_regs;

    localparam int          NREGS       = 8;
    localparam int          WAIT_CYCLES = 2;
    localparam logic [31:0] ID_VALUE    = 32'hA5B0_0001;
`ifdef APB_SLAVE_WAIT_EN
    localparam int EXP_LAT = 1 + WAIT_CYCLES;
`else
    localparam int EXP_LAT = 1;
`endif

    logic        PCLK = 1'b0;
    logic        PRESETn;
    logic        PSEL;
    logic        PENABLE;
    logic        PWRITE;
    logic [31:0] PADDR;
    logic [31:0] PWDATA;
    logic [31:0] PRDATA;
    logic        PREADY;
    logic        PSLVERR;

    int n_checks = 0;
    int n_pass   = 0;

    logic [31:0] model_regs [256];

    apb_slave_regs #(
        .NREGS       (NREGS),
        .WAIT_CYCLES (WAIT_CYCLES),
        .ID_VALUE    (ID_VALUE)
    ) dut (
        .PCLK    (PCLK),
        .PRESETn (PRESETn),
        .PSEL    (PSEL),
        .PENABLE (PENABLE),
        .PWRITE  (PWRITE),
        .PADDR   (PADDR),
        .PWDATA  (PWDATA),
        .PRDATA  (PRDATA),
        .PREADY  (PREADY),
        .PSLVERR (PSLVERR)
    );

    always #5 PCLK = ~PCLK;

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired: got no finish, required finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %08h, expected %08h", tag, got, exp);
        end
    endtask

    function automatic void model_reset();
        for (int i = 0; i < 256; i++) model_regs[i] = 32'h0;
    endfunction

    function automatic bit model_err(input logic [31:0] addr, input bit wr);
        int idx;
        idx = int'((addr / 4) % 256);
        return ((addr % 4) != 0) || (idx >= NREGS) || (wr && idx == 0);
    endfunction

    function automatic logic [31:0] model_read(input logic [31:0] addr);
        int idx;
        idx = int'((addr / 4) % 256);
        if (model_err(addr, 1'b0)) return 32'h0;
        if (idx == 0) return ID_VALUE;
        return model_regs[idx];
    endfunction

    // One complete APB transfer; called at posedge+1 with the bus idle.
    task automatic xfer(input bit wr, input logic [31:0] addr, input logic [31:0] data);
        int          lat;
        bit          seen;
        bit          exp_err;
        logic [31:0] exp_data;
        exp_err  = model_err(addr, wr);
        exp_data = wr ? 32'h0 : model_read(addr);

        PSEL = 1'b1; PENABLE = 1'b0; PWRITE = wr; PADDR = addr; PWDATA = data;
        @(posedge PCLK); #1;
        PENABLE = 1'b1;
        lat = 0; seen = 1'b0;
        while (!seen && lat < 20) begin
            @(posedge PCLK); #1;
            lat++;
            if (PREADY) seen = 1'b1;
        end
        check("pready_rise", 32'(PREADY), 32'd1);
        if (seen) begin
            check("latency", 32'(lat), 32'(EXP_LAT));
            check("pslverr", 32'(PSLVERR), 32'(exp_err));
            check("prdata", PRDATA, exp_data);
            if (wr && !exp_err) model_regs[(addr / 4) % 256] = data;
        end
        $display("xfer %s addr=%08h wdata=%08h prdata=%08h pslverr=%0b lat=%0d",
                 wr ? "WR" : "RD", addr, data, PRDATA, PSLVERR, lat);
        @(posedge PCLK); #1;
        check("pready_one_cycle", 32'(PREADY), 32'd0);
        PSEL = 1'b0; PENABLE = 1'b0;
    endtask

    // Setup a write, then drop PSEL before any access edge.
    task automatic abort_write(input logic [31:0] addr, input logic [31:0] data);
        PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b1; PADDR = addr; PWDATA = data;
        @(posedge PCLK); #1;
        PSEL = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(posedge PCLK); #1;
            check("abort_pready", 32'(PREADY), 32'd0);
        end
        PWRITE = 1'b0;
        $display("abort WR addr=%08h wdata=%08h", addr, data);
    endtask

    initial begin
        int          idx;
        int          lo;
        bit          wr;
        logic [31:0] addr;

        PRESETn = 1'b0; PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
        PADDR = '0; PWDATA = '0;
        model_reset();
        repeat (3) @(posedge PCLK);
        #1;
        check("rst_pready", 32'(PREADY), 32'd0);
        check("rst_pslverr", 32'(PSLVERR), 32'd0);
        check("rst_prdata", PRDATA, 32'h0);
        PRESETn = 1'b1;
        @(posedge PCLK); #1;

        xfer(1'b1, 32'h04, 32'd55);
        xfer(1'b0, 32'h04, 32'h0);
        xfer(1'b0, 32'h00, 32'h0);
        xfer(1'b1, 32'h00, 32'd7);
        xfer(1'b0, 32'h00, 32'h0);
        xfer(1'b1, 32'h20, 32'd9);
        xfer(1'b1, 32'h06, 32'd9);
        xfer(1'b0, 32'h04, 32'h0);
        xfer(1'b0, 32'h06, 32'h0);
        xfer(1'b0, 32'h1C, 32'h0);
        abort_write(32'h08, 32'h1234);
        xfer(1'b0, 32'h08, 32'h0);
        xfer(1'b1, 32'h0C, 32'd3);
        xfer(1'b0, 32'h0C, 32'h0);

        for (int t = 0; t < 80; t++) begin
            idx  = $urandom_range(0, NREGS + 1);
            lo   = ($urandom_range(0, 7) == 0) ? $urandom_range(1, 3) : 0;
            wr   = $urandom_range(0, 1) == 1;
            addr = 32'(idx * 4 + lo);
            xfer(wr, addr, $urandom());
        end

        // Reset in the middle of a write: bank returns to zero, write is lost.
        xfer(1'b1, 32'h04, 32'hCAFE_0001);
        PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b1; PADDR = 32'h04; PWDATA = 32'hDEAD_BEEF;
        @(posedge PCLK); #1;
        PENABLE = 1'b1;
        PRESETn = 1'b0;
        #1;
        check("midrst_pready", 32'(PREADY), 32'd0);
        check("midrst_pslverr", 32'(PSLVERR), 32'd0);
        check("midrst_prdata", PRDATA, 32'h0);
        model_reset();
        $display("reset during WR addr=%08h", 32'h04);
        @(posedge PCLK); #1;
        PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
        @(posedge PCLK); #1;
        PRESETn = 1'b1;
        @(posedge PCLK); #1;
        xfer(1'b0, 32'h04, 32'h0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
